// File: rtl/alu_seq_pkg.sv
// Shared state encodings and opcodes for the nibble-serial ALU.
// Arithmetic and logic opcodes share the same 2-bit field, selected by l.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Arithmetic opcodes (l = 0)
    localparam logic [1:0] OP_INC_C = 2'b00;  // A + cin
    localparam logic [1:0] OP_NEG   = 2'b01;  // ~A + 1 + cin
    localparam logic [1:0] OP_ADD   = 2'b10;  // A + B + cin
    localparam logic [1:0] OP_INC   = 2'b11;  // A + 1 + cin

    // Logic opcodes (l = 1)
    localparam logic [1:0] OP_AND   = 2'b00;
    localparam logic [1:0] OP_OR    = 2'b01;
    localparam logic [1:0] OP_XOR   = 2'b10;
    localparam logic [1:0] OP_NOT   = 2'b11;

endpackage

// File: rtl/alu_seq_alu.sv
// 4-bit combinational ALU used once per nibble by the sequencer.
// Carry is bit 4 of the 5-bit sum; logic operations always give c = 0.
module alu_seq_alu
    import alu_seq_pkg::*;
(
    output logic [3:0] R,
    output logic       z,
    output logic       c,
    output logic       s,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    input  logic [1:0] Op,
    input  logic       l
);

    logic [4:0] sum;

    always_comb begin
        sum = '0;
        if (!l) begin
            case (Op)
                OP_INC_C: sum = {1'b0, A} + {4'b0, cin};
                OP_NEG:   sum = {1'b0, ~A} + 5'd1 + {4'b0, cin};
                OP_ADD:   sum = {1'b0, A} + {1'b0, B} + {4'b0, cin};
                default:  sum = {1'b0, A} + 5'd1 + {4'b0, cin};
            endcase
        end else begin
            case (Op)
                OP_AND:  sum = {1'b0, A & B};
                OP_OR:   sum = {1'b0, A | B};
                OP_XOR:  sum = {1'b0, A ^ B};
                default: sum = {1'b0, ~A};
            endcase
        end
        R = sum[3:0];
        c = sum[4];
        z = (sum[3:0] == 4'd0);
        s = sum[3];
    end

endmodule

// File: rtl/alu_seq.sv
// Nibble-serial W-bit ALU: runs one 4-bit ALU over NIBBLES passes, LSB first,
// rippling the carry through a register between passes.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         l,
    input  logic [1:0]   op,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         z,
    output logic         c,
    output logic         s,
    output logic         busy,
    output logic         done
);

    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q;
    logic [NIBBLES-1:0][3:0]  a_q, b_q, res_q;
    logic                     carry_q, l_q;
    logic [1:0]               op_q;
    logic                     z_q, c_q, s_q;

    logic                     last;
    logic [3:0]               alu_a, alu_r;
    logic [1:0]               alu_op;
    logic                     alu_z, alu_c, alu_s;
    logic                     z_d;

    assign last = (k_q == KW'(NIBBLES - 1));

    // Upper nibbles of arithmetic ops only propagate the carry; negate
    // continues as ~Ak + carry after nibble 0 has applied the +1.
    always_comb begin
        alu_a  = a_q[k_q];
        alu_op = op_q;
        if (!l_q && k_q != '0) begin
            if (op_q != OP_ADD) alu_op = OP_INC_C;
            if (op_q == OP_NEG) alu_a  = ~a_q[k_q];
        end
    end

    alu_seq_alu u_alu (
        .R   (alu_r),
        .z   (alu_z),
        .c   (alu_c),
        .s   (alu_s),
        .A   (alu_a),
        .B   (b_q[k_q]),
        .cin (carry_q),
        .Op  (alu_op),
        .l   (l_q)
    );

    // On the final pass the lower nibbles are already in res_q.
    always_comb begin
        z_d = alu_z;
        for (int i = 0; i < NIBBLES - 1; i++)
            if (res_q[i] != 4'd0) z_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            l_q     <= 1'b0;
            op_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    carry_q <= cin;
                    l_q     <= l;
                    op_q    <= op;
                    k_q     <= '0;
                end
                RUN: begin
                    res_q[k_q] <= alu_r;
                    carry_q    <= alu_c;
                    k_q        <= last ? '0 : k_q + 1'b1;
                    if (last) begin
                        z_q <= z_d;
                        c_q <= ~l_q & alu_c;
                        s_q <= alu_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = res_q;
    assign z      = z_q;
    assign c      = c_q;
    assign s      = s_q;

endmodule
